pds_port_rx: RTL and testbench
==============================

Name: pds_port_rx

Overview:
- Store-and-forward packet receiver for one port of the pds packet path.
- Accepts the byte-serial packet stream that the bench driver produces on pds_if.
- Checks each packet: destination address, parity, framing.
- Buffers only good packets and replays them on a valid/ready output stream for downstream port logic.
- Bad packets are rolled back out of the buffer and flagged.

Parameters:
- PORTNO, 1, this port's address; compared against header bits [1:0].
- DEPTH, 128, buffer depth in bytes; power of two, at least 128.
- CNT_W, 16, width of the good-packet counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  high for every byte of a packet; frames are contiguous.
- in_data  input  8  packet byte.
- in_busy  output  1  sender must not start a packet while this is high.
- out_valid  output  1  out_data holds a buffered byte.
- out_data  output  8  buffered byte.
- out_sop  output  1  out_data is a header byte.
- out_eop  output  1  out_data is the last payload byte, or the header when len=0.
- out_ready  input  1  downstream accepts the byte when out_valid & out_ready.
- err_parity  output  1  one-cycle pulse: parity mismatch.
- err_addr  output  1  one-cycle pulse: address mismatch.
- err_frame  output  1  one-cycle pulse: truncated, overlong, or overflow-dropped packet.
- pkt_cnt  output  CNT_W  count of committed packets; wraps.

Behaviour:
- Packet format:
  - byte0 = header {len[5:0], addr[1:0]}.
  - Then len payload bytes (0..63).
  - Then one parity byte = XOR of header and all payload bytes.
  - in_valid must be low for at least 1 cycle between packets.
- Reset: all outputs 0, state IDLE. wr_ptr, commit_ptr and rd_ptr are 0 and the buffer is empty. Any packet in progress is discarded.
- Write FSM states: IDLE, PAYLOAD, PARITY, DROP.
  - IDLE, in_valid & !in_busy:
    - write header at wr_ptr; parity_acc = byte; remaining = len.
    - next state is PARITY if len=0, else PAYLOAD.
  - IDLE, in_valid & in_busy: enter DROP and pulse err_frame. Nothing is written.
  - PAYLOAD, in_valid:
    - write byte; parity_acc ^= byte; remaining--.
    - enter PARITY when remaining reaches 0.
  - PAYLOAD or PARITY, !in_valid (truncation): wr_ptr <= commit_ptr; pulse err_frame; go to IDLE.
  - PARITY, in_valid:
    - The parity byte is not stored.
    - If byte==parity_acc and addr==PORTNO[1:0]: commit_ptr <= wr_ptr and pkt_cnt++.
    - Otherwise wr_ptr <= commit_ptr and pulse err_parity and/or err_addr. Both pulse together if both checks fail.
    - Go to DROP.
  - DROP: wait for !in_valid, then go to IDLE.
    - If DROP was entered from PARITY and in_valid is still high on the next cycle, the packet is overlong: pulse err_frame once.
    - An already-committed packet stays committed.
- Error pulses and pkt_cnt update appear in the cycle after the deciding byte is sampled.
- in_busy = (DEPTH - (wr_ptr - commit_ptr... rd_ptr)) < 64; computed with ptr width log2(DEPTH)+1. It is registered and evaluated in all states. It only affects packet start.
- Read side:
  - Reads only bytes between rd_ptr and commit_ptr, so uncommitted bytes are never visible.
  - out_valid rises 1 cycle after commit_ptr passes rd_ptr. Minimum latency is parity-byte edge + 2 cycles to header on the output.
  - The read side parses the header to set out_sop, load its own remaining count, and assert out_eop on the last byte.
  - out_data, out_sop and out_eop hold stable while out_valid & !out_ready.
  - Full throughput is 1 byte/cycle. Read and write operate concurrently.
- Pointer wrap is modulo DEPTH. Simultaneous commit and read-out is legal.

Test Plan:
- Header 8'h0D (len=3, addr=1), payload 11,22,33, parity = 0D^11^22^33 = 0x0D, out_ready=1 -> out stream 0D(sop),11,22,33(eop); pkt_cnt=1; no error pulses.
- Same packet with parity byte 0x00 -> err_parity pulse 1 cycle after the parity byte; out_valid never rises; pkt_cnt unchanged; the next good packet outputs correctly.
- Header 8'h0E (addr=2) with correct parity -> err_addr pulse only; nothing output.
- in_valid drops after 2 of 3 payload bytes -> err_frame pulse; buffer rolled back; a following good packet is output intact.
- out_ready=0 while two 63-byte good packets are sent -> in_busy rises once free space < 64. A third packet started while busy -> err_frame and dropped. Release out_ready -> 128 bytes output in order with stable data during stalls.
- Assert rst mid-packet and with buffered data -> all outputs 0 immediately, buffer empty. A fresh packet after reset is accepted normally.

Source files
------------

// File: rtl/pds_port_rx_if.sv
// pds_port_rx_if: byte-serial packet input and buffered valid/ready output stream of one pds port
interface pds_port_rx_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_busy;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;
    modport master (output in_valid, in_data, out_ready, input in_busy, out_valid, out_data, out_sop, out_eop);
    modport slave (input in_valid, in_data, out_ready, output in_busy, out_valid, out_data, out_sop, out_eop);
endinterface

// File: rtl/pds_port_rx.sv
// pds_port_rx: store-and-forward packet receiver; buffers good packets, rolls back and flags bad ones
module pds_port_rx #(
    parameter int PORTNO = 1,
    parameter int DEPTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pds_port_rx_if.slave     pds,
    output logic             err_parity,
    output logic             err_addr,
    output logic             err_frame,
    output logic [CNT_W-1:0] pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [1:0] PA = 2'(PORTNO);
    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;
    state_t state, state_n;
    logic [7:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [7:0] parity_acc, rd_byte;
    logic [5:0] remaining, rd_rem;
    logic [1:0] addr;
    logic over_chk, rd_body;
    logic wr_en, good, bad_par, bad_addr, trunc, frame, rollback, rd_load;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (pds.in_valid) state_n = pds.in_busy ? DROP : (pds.in_data[7:2] == 6'd0 ? PARITY : PAYLOAD);
            PAYLOAD: state_n = !pds.in_valid ? IDLE : (remaining == 6'd1 ? PARITY : PAYLOAD);
            PARITY: state_n = pds.in_valid ? DROP : IDLE;
            DROP: if (!pds.in_valid) state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_en = pds.in_valid & ((state == IDLE & !pds.in_busy) | state == PAYLOAD);
        good = state == PARITY & pds.in_valid & pds.in_data == parity_acc & addr == PA;
        bad_par = state == PARITY & pds.in_valid & pds.in_data != parity_acc;
        bad_addr = state == PARITY & pds.in_valid & addr != PA;
        trunc = (state == PAYLOAD | state == PARITY) & !pds.in_valid;
        frame = trunc | (state == IDLE & pds.in_valid & pds.in_busy) | (state == DROP & over_chk & pds.in_valid);
        rollback = trunc | bad_par | bad_addr;
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= pds.in_data;

    // occupancy counts uncommitted bytes too, so a started packet can always finish
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            commit_ptr <= '0;
            parity_acc <= '0;
            remaining <= '0;
            addr <= '0;
            over_chk <= 1'b0;
            err_parity <= 1'b0;
            err_addr <= 1'b0;
            err_frame <= 1'b0;
            pkt_cnt <= '0;
            pds.in_busy <= 1'b0;
        end else begin
            wr_ptr <= rollback ? commit_ptr : wr_ptr + PW'(wr_en);
            if (good) commit_ptr <= wr_ptr;
            if (wr_en) parity_acc <= state == IDLE ? pds.in_data : parity_acc ^ pds.in_data;
            if (wr_en) remaining <= state == IDLE ? pds.in_data[7:2] : remaining - 6'd1;
            if (wr_en & state == IDLE) addr <= pds.in_data[1:0];
            over_chk <= state == PARITY & pds.in_valid;
            err_parity <= bad_par;
            err_addr <= bad_addr;
            err_frame <= frame;
            pkt_cnt <= pkt_cnt + CNT_W'(good);
            pds.in_busy <= PW'(DEPTH) - (wr_ptr - rd_ptr) < PW'(64);
        end

    assign rd_byte = mem[rd_ptr[AW-1:0]];
    assign rd_load = rd_ptr != commit_ptr & (!pds.out_valid | pds.out_ready);

    // read side re-parses headers from the buffer to regenerate sop/eop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            rd_rem <= '0;
            rd_body <= 1'b0;
            pds.out_valid <= 1'b0;
            pds.out_data <= '0;
            pds.out_sop <= 1'b0;
            pds.out_eop <= 1'b0;
        end else if (rd_load) begin
            rd_ptr <= rd_ptr + PW'(1);
            pds.out_valid <= 1'b1;
            pds.out_data <= rd_byte;
            pds.out_sop <= !rd_body;
            pds.out_eop <= rd_body ? rd_rem == 6'd1 : rd_byte[7:2] == 6'd0;
            rd_rem <= rd_body ? rd_rem - 6'd1 : rd_byte[7:2];
            rd_body <= rd_body ? rd_rem != 6'd1 : rd_byte[7:2] != 6'd0;
        end else if (pds.out_ready) pds.out_valid <= 1'b0;
endmodule

// File: tb/tb_pds_port_rx.sv
// tb_pds_port_rx: table of directed packets plus hand-written backpressure, timing and reset sequences
module tb_pds_port_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_parity, err_addr, err_frame;
    logic [15:0] pkt_cnt;
    pds_port_rx_if pds();

    pds_port_rx #(.PORTNO(1), .DEPTH(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pds(pds),
        .err_parity(err_parity), .err_addr(err_addr), .err_frame(err_frame), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  hdr;
        logic [31:0] pl;
        logic [2:0]  nsent;
        logic        send_par;
        logic [7:0]  par;
        logic        extra;
        logic        e_par;
        logic        e_addr;
        logic        e_frame;
        logic        good;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] tx_q [$];
    logic [9:0] exp_q [$];
    int checks = 0, errors = 0, n_par = 0, n_addr = 0, n_frame = 0, n_out = 0, cnt = 0;
    int p0, a0, f0, o0;
    logic stall_prev = 1'b0;
    logic [9:0] prev = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_q;
        foreach (tx_q[i]) begin
            pds.in_valid = 1'b1;
            pds.in_data = tx_q[i];
            tick;
        end
    endtask

    task automatic idle(input int n);
        pds.in_valid = 1'b0;
        pds.in_data = 8'h00;
        repeat (n) tick;
    endtask

    task automatic expect_q;
        int len;
        len = int'(tx_q[0][7:2]);
        exp_q.push_back({1'b1, len == 0, tx_q[0]});
        for (int i = 1; i <= len; i++) exp_q.push_back({1'b0, i == len, tx_q[i]});
    endtask

    task automatic build_vec(input vec_t v);
        tx_q.delete();
        tx_q.push_back(v.hdr);
        for (int i = 0; i < int'(v.nsent); i++) tx_q.push_back(v.pl[8*i +: 8]);
        if (v.send_par) tx_q.push_back(v.par);
        if (v.extra) tx_q.push_back(8'h99);
    endtask

    task automatic build_big(input logic [7:0] base);
        logic [7:0] p;
        p = 8'hFD;
        tx_q.delete();
        tx_q.push_back(8'hFD);
        for (int i = 0; i < 63; i++) begin
            tx_q.push_back(base + 8'(i));
            p ^= base + 8'(i);
        end
        tx_q.push_back(p);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick;
        repeat (3) tick;
        check(name, exp_q.size(), 0);
    endtask

    // output scoreboard, stall-stability check and error pulse counters
    always @(negedge clk) begin
        logic [9:0] cur, e;
        cur = {pds.out_sop, pds.out_eop, pds.out_data};
        if (!rst) begin
            n_par += int'(err_parity);
            n_addr += int'(err_addr);
            n_frame += int'(err_frame);
            if (pds.out_valid && stall_prev) check("stall hold {sop,eop,data}", cur, prev);
            if (pds.out_valid && pds.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected out byte: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out byte {sop,eop,data}", cur, e);
                end
            end
        end
        stall_prev = !rst && pds.out_valid && !pds.out_ready;
        prev = cur;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h0D, 32'h00332211, 3'd3, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h0D, 32'h00332211, 3'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h0E, 32'h00332211, 3'd3, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h0D, 32'h00002211, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h0D, 32'h00CCBBAA, 3'd3, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 32'h00000000, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h0E, 32'h00332211, 3'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h05, 32'h00000042, 3'd1, 1'b1, 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{8'h09, 32'h00000201, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h09, 32'h00000201, 3'd2, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pds.in_valid = 1'b0;
        pds.in_data = 8'h00;
        pds.out_ready = 1'b1;
        repeat (2) tick;
        check("reset outputs", {pds.in_busy, pds.out_valid, pds.out_data, pds.out_sop, pds.out_eop,
                                err_parity, err_addr, err_frame, pkt_cnt}, 0);
        rst = 1'b0;
        tick;

        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        drive_q;
        check("errors one cycle after parity byte", {err_parity, err_addr, err_frame}, 3'b100);
        idle(1);
        check("err_parity single cycle", err_parity, 0);
        idle(3);
        check("bad parity nothing output", n_out, 0);
        check("bad parity pkt_cnt", pkt_cnt, 0);

        for (int k = 0; k < 10; k++) begin
            p0 = n_par;
            a0 = n_addr;
            f0 = n_frame;
            build_vec(vecs[k]);
            if (vecs[k].good) begin
                expect_q;
                cnt++;
            end
            drive_q;
            idle(1);
            drain($sformatf("vec%0d out stream", k));
            check($sformatf("vec%0d err_parity", k), n_par - p0, 32'(vecs[k].e_par));
            check($sformatf("vec%0d err_addr", k), n_addr - a0, 32'(vecs[k].e_addr));
            check($sformatf("vec%0d err_frame", k), n_frame - f0, 32'(vecs[k].e_frame));
            check($sformatf("vec%0d pkt_cnt", k), pkt_cnt, cnt);
        end

        pds.out_ready = 1'b0;
        o0 = n_out;
        f0 = n_frame;
        build_big(8'h40);
        expect_q;
        drive_q;
        idle(2);
        check("busy low after first 63-byte packet", pds.in_busy, 0);
        build_big(8'h80);
        expect_q;
        drive_q;
        idle(2);
        cnt += 2;
        check("busy high after second 63-byte packet", pds.in_busy, 1);
        build_big(8'hC0);
        drive_q;
        idle(2);
        check("start while busy err_frame", n_frame - f0, 1);
        check("start while busy pkt_cnt", pkt_cnt, cnt);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            pds.out_ready = 1'($urandom_range(0, 1));
            tick;
        end
        pds.out_ready = 1'b1;
        idle(3);
        check("backpressure drained", exp_q.size(), 0);
        check("backpressure byte count", n_out - o0, 128);
        check("busy low after drain", pds.in_busy, 0);

        pds.out_ready = 1'b0;
        tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        drive_q;
        idle(3);
        check("data buffered before reset", pds.out_valid, 1);
        pds.in_valid = 1'b1;
        pds.in_data = 8'h0D;
        tick;
        pds.in_data = 8'h11;
        tick;
        #2 rst = 1'b1;
        #1;
        check("async reset clears outputs", {pds.in_busy, pds.out_valid, pds.out_data, pds.out_sop, pds.out_eop,
                                             err_parity, err_addr, err_frame, pkt_cnt}, 0);
        exp_q.delete();
        cnt = 0;
        idle(2);
        rst = 1'b0;
        pds.out_ready = 1'b1;
        idle(1);
        check("buffer empty after reset", pds.out_valid, 0);
        tx_q = '{8'h05, 8'h42, 8'h47};
        expect_q;
        cnt++;
        drive_q;
        idle(1);
        drain("packet after reset");
        check("pkt_cnt after reset", pkt_cnt, cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
